// File: rtl/alu_arbiter_if.sv
// Request, ALU-side and response signal bundle for the shared-ALU arbiter.
// The slave view is taken by the arbiter; the master view is taken by clients, the ALU and the consumer.
`timescale 1ns/1ps
interface alu_arbiter_if #(
  parameter int DATA_W = 32
);
  logic              req0_valid;
  logic              req0_ready;
  logic [DATA_W-1:0] req0_A;
  logic [DATA_W-1:0] req0_B;
  logic              req0_cin;
  logic [2:0]        req0_Select;

  logic              req1_valid;
  logic              req1_ready;
  logic [DATA_W-1:0] req1_A;
  logic [DATA_W-1:0] req1_B;
  logic              req1_cin;
  logic [2:0]        req1_Select;

  logic [DATA_W-1:0] alu_A;
  logic [DATA_W-1:0] alu_B;
  logic              alu_cin;
  logic [2:0]        alu_Select;
  logic [DATA_W-1:0] alu_Output;
  logic              alu_isNegative;
  logic              alu_isZero;
  logic              alu_Overflow;
  logic              alu_CarryOut;

  logic              rsp_valid;
  logic              rsp_ready;
  logic              rsp_id;
  logic [DATA_W-1:0] rsp_Output;
  logic [3:0]        rsp_flags;

  modport slave (
    input  req0_valid, req0_A, req0_B, req0_cin, req0_Select,
    output req0_ready,
    input  req1_valid, req1_A, req1_B, req1_cin, req1_Select,
    output req1_ready,
    output alu_A, alu_B, alu_cin, alu_Select,
    input  alu_Output, alu_isNegative, alu_isZero, alu_Overflow, alu_CarryOut,
    output rsp_valid, rsp_id, rsp_Output, rsp_flags,
    input  rsp_ready
  );

  modport master (
    output req0_valid, req0_A, req0_B, req0_cin, req0_Select,
    input  req0_ready,
    output req1_valid, req1_A, req1_B, req1_cin, req1_Select,
    input  req1_ready,
    input  alu_A, alu_B, alu_cin, alu_Select,
    output alu_Output, alu_isNegative, alu_isZero, alu_Overflow, alu_CarryOut,
    input  rsp_valid, rsp_id, rsp_Output, rsp_flags,
    output rsp_ready
  );
endinterface

// File: rtl/alu_arbiter.sv
// Round-robin arbiter and load/execute sequencer in front of the shared 32-bit ALU.
// One operation is in flight at a time; results return with the requester ID.
`timescale 1ns/1ps
module alu_arbiter #(
  parameter int DATA_W        = 32,
  parameter int SETTLE_CYCLES = 1
) (
  input  logic         clk,
  input  logic         rst,
  alu_arbiter_if.slave bus
);

  localparam logic [2:0] SEL_PARK = 3'b111;
  localparam logic [3:0] CNT_INIT = 4'(SETTLE_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_EXEC,
    S_RESP
  } state_t;

  // Opcode 111 is the park code on the ALU bus, so a request for it is served as add.
  function automatic logic [2:0] remap_sel(input logic [2:0] sel);
    return (sel == SEL_PARK) ? 3'b000 : sel;
  endfunction

  state_t            r_state;
  logic              r_last_grant;
  logic [3:0]        r_cnt;
  logic [DATA_W-1:0] r_a;
  logic [DATA_W-1:0] r_b;
  logic              r_cin;
  logic [2:0]        r_op;
  logic              r_id;
  logic [2:0]        r_alu_sel;
  logic              r_rsp_valid;
  logic              r_rsp_id;
  logic [DATA_W-1:0] r_rsp_out;
  logic [3:0]        r_rsp_flags;

  logic w_grant;
  logic w_ready0;
  logic w_ready1;
  logic w_accept;

  always_comb begin
    w_grant  = (bus.req0_valid && bus.req1_valid) ? ~r_last_grant : bus.req1_valid;
    w_ready0 = (r_state == S_IDLE) && !w_grant && !rst;
    w_ready1 = (r_state == S_IDLE) &&  w_grant && !rst;
    w_accept = (bus.req0_valid && w_ready0) || (bus.req1_valid && w_ready1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_last_grant <= 1'b1;
      r_cnt        <= 4'd0;
      r_a          <= '0;
      r_b          <= '0;
      r_cin        <= 1'b0;
      r_op         <= 3'b000;
      r_id         <= 1'b0;
      r_alu_sel    <= SEL_PARK;
      r_rsp_valid  <= 1'b0;
      r_rsp_id     <= 1'b0;
      r_rsp_out    <= '0;
      r_rsp_flags  <= 4'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_a     <= w_grant ? bus.req1_A   : bus.req0_A;
            r_b     <= w_grant ? bus.req1_B   : bus.req0_B;
            r_cin   <= w_grant ? bus.req1_cin : bus.req0_cin;
            r_op    <= remap_sel(w_grant ? bus.req1_Select : bus.req0_Select);
            r_id    <= w_grant;
            r_state <= S_LOAD;
          end
        end
        S_LOAD: begin
          // Leaving park here guarantees the ALU always sees a Select change.
          r_alu_sel <= r_op;
          r_cnt     <= CNT_INIT;
          r_state   <= S_EXEC;
        end
        S_EXEC: begin
          if (r_cnt == 4'd0) begin
            r_rsp_out    <= bus.alu_Output;
            r_rsp_flags  <= {bus.alu_isNegative, bus.alu_isZero,
                             bus.alu_Overflow, bus.alu_CarryOut};
            r_rsp_id     <= r_id;
            r_rsp_valid  <= 1'b1;
            r_last_grant <= r_id;
            r_alu_sel    <= SEL_PARK;
            r_state      <= S_RESP;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        S_RESP: begin
          if (bus.rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_state     <= S_IDLE;
          end
        end
        default: begin
          r_alu_sel <= SEL_PARK;
          r_state   <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.req0_ready = w_ready0;
  assign bus.req1_ready = w_ready1;
  assign bus.alu_A      = r_a;
  assign bus.alu_B      = r_b;
  assign bus.alu_cin    = r_cin;
  assign bus.alu_Select = r_alu_sel;
  assign bus.rsp_valid  = r_rsp_valid;
  assign bus.rsp_id     = r_rsp_id;
  assign bus.rsp_Output = r_rsp_out;
  assign bus.rsp_flags  = r_rsp_flags;

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: behavioural ALU, per-requester job queues, and a scoreboard monitor.
// A second instance with a longer settle time covers the exact sequencing timing.
`timescale 1ns/1ps
module tb_alu_arbiter;

  localparam int S1 = 1;
  localparam int S4 = 4;

  typedef struct {
    logic        id;
    logic [31:0] a;
    logic [31:0] b;
    logic        cin;
    logic [2:0]  sel;
    logic [2:0]  esel;
    logic [31:0] eout;
    logic [3:0]  eflg;
    int          acc;
  } job_t;

  logic clk;
  logic rst;
  int   cyc;
  int   n_chk;
  int   n_fail;
  int   bp_mode;

  job_t pq0[$];
  job_t pq1[$];
  job_t sb[$];

  alu_arbiter_if bus1 ();
  alu_arbiter_if bus4 ();

  alu_arbiter #(.SETTLE_CYCLES(S1)) dut1 (.clk(clk), .rst(rst), .bus(bus1));
  alu_arbiter #(.SETTLE_CYCLES(S4)) dut4 (.clk(clk), .rst(rst), .bus(bus4));

  // Behavioural ALU: returns {N,Z,V,C,out}; 111 yields a marker value.
  function automatic logic [35:0] alu_f(input logic [31:0] a, input logic [31:0] b,
                                        input logic ci, input logic [2:0] s);
    logic [32:0] sum;
    logic [31:0] o;
    logic        v;
    logic        c;
    sum = {1'b0, a} + {1'b0, b} + {32'd0, ci};
    o = 32'd0; v = 1'b0; c = 1'b0;
    case (s)
      3'd0: begin o = sum[31:0]; c = sum[32]; v = (a[31] == b[31]) && (o[31] != a[31]); end
      3'd1: o = a & b;
      3'd2: o = a | b;
      3'd3: o = a ^ b;
      3'd4: o = ~(a | b);
      3'd5: o = a << b[4:0];
      3'd6: o = a >> b[4:0];
      default: o = 32'hDEADBEEF;
    endcase
    return {o[31], (o == 32'd0), v, c, o};
  endfunction

  assign {bus1.alu_isNegative, bus1.alu_isZero, bus1.alu_Overflow, bus1.alu_CarryOut, bus1.alu_Output} =
         alu_f(bus1.alu_A, bus1.alu_B, bus1.alu_cin, bus1.alu_Select);
  assign {bus4.alu_isNegative, bus4.alu_isZero, bus4.alu_Overflow, bus4.alu_CarryOut, bus4.alu_Output} =
         alu_f(bus4.alu_A, bus4.alu_B, bus4.alu_cin, bus4.alu_Select);

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic job_t mk(input logic [31:0] a, input logic [31:0] b, input logic ci,
                              input logic [2:0] sel, input logic [2:0] esel,
                              input logic [31:0] eo, input logic [3:0] ef);
    job_t j;
    j.id = 1'b0; j.a = a; j.b = b; j.cin = ci; j.sel = sel;
    j.esel = esel; j.eout = eo; j.eflg = ef; j.acc = 0;
    return j;
  endfunction

  function automatic job_t mk_rand();
    logic [31:0] a;
    logic [31:0] b;
    logic        ci;
    logic [2:0]  sel;
    logic [2:0]  es;
    logic [35:0] r;
    a   = $urandom;
    b   = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 40)) : $urandom;
    ci  = 1'($urandom_range(0, 1));
    sel = 3'($urandom_range(0, 7));
    es  = (sel == 3'd7) ? 3'd0 : sel;
    r   = alu_f(a, b, ci, es);
    return mk(a, b, ci, sel, es, r[31:0], r[35:32]);
  endfunction

  // Requester drivers: hold valid and payload of the queue head until it is accepted.
  initial begin
    bus1.req0_valid = 0; bus1.req0_A = 0; bus1.req0_B = 0; bus1.req0_cin = 0; bus1.req0_Select = 0;
    bus1.req1_valid = 0; bus1.req1_A = 0; bus1.req1_B = 0; bus1.req1_cin = 0; bus1.req1_Select = 0;
    forever begin
      @(posedge clk); #1;
      if (pq0.size() > 0) begin
        bus1.req0_valid = 1; bus1.req0_A = pq0[0].a; bus1.req0_B = pq0[0].b;
        bus1.req0_cin = pq0[0].cin; bus1.req0_Select = pq0[0].sel;
      end else bus1.req0_valid = 0;
      if (pq1.size() > 0) begin
        bus1.req1_valid = 1; bus1.req1_A = pq1[0].a; bus1.req1_B = pq1[0].b;
        bus1.req1_cin = pq1[0].cin; bus1.req1_Select = pq1[0].sel;
      end else bus1.req1_valid = 0;
    end
  end

  int hold;
  initial begin
    bus1.rsp_ready = 1;
    hold = 0;
    forever begin
      @(posedge clk); #1;
      case (bp_mode)
        1: bus1.rsp_ready = 1'($urandom_range(0, 1));
        2: begin
          hold = bus1.rsp_valid ? hold + 1 : 0;
          bus1.rsp_ready = (hold > 5);
        end
        default: bus1.rsp_ready = 1;
      endcase
    end
  end

  // Monitor / scoreboard for the SETTLE_CYCLES=1 instance.
  logic        model_last;
  logic        a0, a1, eg;
  logic        prev_v, prev_r;
  logic        snap_id;
  logic [31:0] snap_out;
  logic [3:0]  snap_flg;
  int          run;
  job_t        mj;

  always @(negedge clk) begin
    if (rst) begin
      sb.delete();
      model_last = 1'b1;
      run = 0; prev_v = 0; prev_r = 0;
    end else begin
      a0 = bus1.req0_valid && bus1.req0_ready;
      a1 = bus1.req1_valid && bus1.req1_ready;
      if (a0 || a1) begin
        chk("single_grant", {a0, a1} == 2'b11, 0);
        eg = (bus1.req0_valid && bus1.req1_valid) ? ~model_last : bus1.req1_valid;
        chk("grant_id", a1, eg);
        if (a1 && pq1.size() > 0) mj = pq1.pop_front();
        else if (pq0.size() > 0) mj = pq0.pop_front();
        mj.id = eg; mj.acc = cyc;
        sb.push_back(mj);
        model_last = eg;
      end
      if (bus1.alu_Select != 3'b111) begin
        run++;
        if (sb.size() > 0) begin
          chk("alu_sel", bus1.alu_Select, sb[0].esel);
          chk("alu_ops", {bus1.alu_A, bus1.alu_B}, {sb[0].a, sb[0].b});
          chk("alu_cin", bus1.alu_cin, sb[0].cin);
        end
      end else begin
        if (run > 0) chk("exec_len", run, S1);
        run = 0;
      end
      if (bus1.rsp_valid && !prev_v) begin
        chk("rsp_expected", sb.size(), 1);
        if (sb.size() > 0) chk("latency", cyc - sb[0].acc - 1, 1 + S1);
      end
      if (bus1.rsp_valid) chk("req_ready_busy", {bus1.req0_ready, bus1.req1_ready}, 0);
      if (prev_v && !prev_r) begin
        chk("hold_valid", bus1.rsp_valid, 1);
        chk("hold_data", {bus1.rsp_id, bus1.rsp_Output, bus1.rsp_flags}, {snap_id, snap_out, snap_flg});
      end
      if (bus1.rsp_valid && bus1.rsp_ready && sb.size() > 0) begin
        mj = sb.pop_front();
        chk("rsp_id", bus1.rsp_id, mj.id);
        chk("rsp_out", bus1.rsp_Output, mj.eout);
        chk("rsp_flags", bus1.rsp_flags, mj.eflg);
      end
      prev_v = bus1.rsp_valid; prev_r = bus1.rsp_ready;
      snap_id = bus1.rsp_id; snap_out = bus1.rsp_Output; snap_flg = bus1.rsp_flags;
    end
  end

  task automatic drain(input int budget);
    int k;
    k = 0;
    while ((pq0.size() != 0 || pq1.size() != 0 || sb.size() != 0) && k < budget) begin
      @(negedge clk); k++;
    end
    chk("drain_in_time", k < budget, 1);
    repeat (2) @(negedge clk);
    #2;
  endtask

  task automatic d4_op(input logic id, input logic [31:0] a, input logic [31:0] b, input logic ci,
                       input logic [2:0] sel, input logic [2:0] esel,
                       input logic [31:0] eo, input logic [3:0] ef);
    int   k;
    logic rdy;
    @(posedge clk); #1;
    if (id) begin
      bus4.req1_valid = 1; bus4.req1_A = a; bus4.req1_B = b; bus4.req1_cin = ci; bus4.req1_Select = sel;
    end else begin
      bus4.req0_valid = 1; bus4.req0_A = a; bus4.req0_B = b; bus4.req0_cin = ci; bus4.req0_Select = sel;
    end
    k = 0; rdy = 0;
    while (!rdy && k < 20) begin
      @(negedge clk);
      rdy = id ? bus4.req1_ready : bus4.req0_ready;
      k++;
    end
    chk("d4_accept", rdy, 1);
    @(posedge clk); #1;
    bus4.req0_valid = 0; bus4.req1_valid = 0;
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      chk("d4_rsp_valid_timing", bus4.rsp_valid, c == 6);
      chk("d4_sel_timing", bus4.alu_Select, (c >= 2 && c <= 5) ? esel : 3'b111);
    end
    chk("d4_rsp_id", bus4.rsp_id, id);
    chk("d4_rsp_out", bus4.rsp_Output, eo);
    chk("d4_rsp_flags", bus4.rsp_flags, ef);
    @(negedge clk);
    chk("d4_rsp_done", bus4.rsp_valid, 0);
  endtask

  initial begin
    int k;
    n_chk = 0; n_fail = 0; cyc = 0; bp_mode = 0;
    bus4.req0_valid = 0; bus4.req0_A = 0; bus4.req0_B = 0; bus4.req0_cin = 0; bus4.req0_Select = 0;
    bus4.req1_valid = 0; bus4.req1_A = 0; bus4.req1_B = 0; bus4.req1_cin = 0; bus4.req1_Select = 0;
    bus4.rsp_ready = 1;
    rst = 1;
    repeat (3) @(negedge clk);
    #2;
    chk("rst_rsp_valid", bus1.rsp_valid, 0);
    chk("rst_rsp_id", bus1.rsp_id, 0);
    chk("rst_rsp_out", bus1.rsp_Output, 0);
    chk("rst_rsp_flags", bus1.rsp_flags, 0);
    chk("rst_alu_ops", {bus1.alu_A, bus1.alu_B, bus1.alu_cin}, 0);
    chk("rst_alu_sel", bus1.alu_Select, 3'b111);
    chk("rst_ready", {bus1.req0_ready, bus1.req1_ready}, 0);
    chk("rst_alu_sel4", bus4.alu_Select, 3'b111);
    rst = 0;
    @(negedge clk); #2;
    chk("idle_ready", {bus1.req0_ready, bus1.req1_ready}, 2'b10);

    // Round-robin from reset: both requesters continuously valid.
    for (int i = 0; i < 3; i++) begin
      pq0.push_back(mk(32'hFFFF0000, 32'h0F0F0F0F, 0, 3'b011, 3'b011, 32'hF0F00F0F, 4'b1000));
      pq1.push_back(mk(32'h0, 32'h0, 0, 3'b100, 3'b100, 32'hFFFFFFFF, 4'b1000));
    end
    drain(200);

    pq0.push_back(mk(32'h7FFFFFFF, 32'h1, 0, 3'b000, 3'b000, 32'h80000000, 4'b1010));
    drain(100);

    pq1.push_back(mk(32'd3, 32'd4, 0, 3'b111, 3'b000, 32'd7, 4'b0000));
    pq0.push_back(mk(32'd1, 32'd31, 0, 3'b101, 3'b101, 32'h80000000, 4'b1000));
    drain(100);

    // Response backpressure: five stalled cycles per response.
    bp_mode = 2;
    pq0.push_back(mk_rand());
    pq1.push_back(mk_rand());
    drain(200);
    bp_mode = 0;

    // Reset during EXEC discards the operation.
    pq0.push_back(mk(32'd10, 32'd20, 1, 3'b000, 3'b000, 32'd31, 4'b0000));
    k = 0;
    while (sb.size() == 0 && k < 50) begin @(negedge clk); #2; k++; end
    chk("pre_reset_accept", sb.size(), 1);
    @(negedge clk);
    @(negedge clk); #2;
    rst = 1; #1;
    chk("midrst_rsp_valid", bus1.rsp_valid, 0);
    chk("midrst_alu_sel", bus1.alu_Select, 3'b111);
    chk("midrst_ready", {bus1.req0_ready, bus1.req1_ready}, 0);
    repeat (2) @(negedge clk);
    #2; rst = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("no_rsp_after_rst", bus1.rsp_valid, 0);
    end
    pq1.push_back(mk(32'hFFFFFFFF, 32'h1, 0, 3'b000, 3'b000, 32'h0, 4'b0101));
    drain(100);

    // Randomized traffic with random response backpressure.
    bp_mode = 1;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk); #2;
      if ($urandom_range(0, 3) == 0 && pq0.size() < 2) pq0.push_back(mk_rand());
      if ($urandom_range(0, 3) == 0 && pq1.size() < 2) pq1.push_back(mk_rand());
    end
    drain(3000);
    bp_mode = 0;

    // SETTLE_CYCLES=4 instance: exact load/execute/response timing.
    d4_op(0, 32'd5, 32'd9, 1, 3'b000, 3'b000, 32'd15, 4'b0000);
    d4_op(1, 32'h80000000, 32'd4, 0, 3'b110, 3'b110, 32'h08000000, 4'b0000);
    d4_op(0, 32'h00000006, 32'h00000003, 0, 3'b001, 3'b001, 32'h2, 4'b0000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Two-port arbiter and sequencer for the shared 32-bit ALU. Accepts operation requests (operands, carry-in, 3-bit Select) from two requesters over valid/ready handshakes, grants round-robin, drives the ALU operand and Select lines through a load/execute sequence, samples Output and the N/Z/V/C flags, and returns them with the requester ID over a valid/ready response channel. It sits between the ALU and its clients, for example the execute stage and a multi-cycle helper unit.

## Interface
- SETTLE_CYCLES, 1: EXEC cycles Select is held before sampling; legal 1..15.

- clk  in  1  rising-edge clock
- rst  in  1  reset, asynchronous, active-high
- req0_valid / req1_valid  in  1  request present
- req0_ready / req1_ready  out  1  request accepted this cycle
- req0_A, req0_B / req1_A, req1_B  in  32  operands
- req0_cin / req1_cin  in  1  carry-in
- req0_Select / req1_Select  in  3  ALU opcode (000 add, 001 and, 010 or, 011 xor, 100 nor, 101 shl, 110 shr)
- alu_A, alu_B  out  32  to ALU operands
- alu_cin  out  1  to ALU carry-in
- alu_Select  out  3  to ALU Select
- alu_Output  in  32  from ALU
- alu_isNegative, alu_isZero, alu_Overflow, alu_CarryOut  in  1  ALU flags
- rsp_valid  out  1  result available
- rsp_ready  in  1  consumer takes result
- rsp_id  out  1  requester served (0/1)
- rsp_Output  out  32  sampled result
- rsp_flags  out  4  {N,Z,V,C} sampled

## Operation
- FSM: IDLE -> LOAD -> EXEC -> RESP -> IDLE.
- IDLE: grant computed combinationally. Only one valid: grant it. Both valid: grant the requester not served last (last_grant register, reset 1, so req0 wins first). reqN_ready = (state==IDLE) & grant==N & !rst; the other ready is 0. On valid&ready, capture A, B, cin, Select and ID; go LOAD.
- Captured Select 3'b111 is remapped to 3'b000 (same function, add).
- LOAD (1 cycle): alu_A/alu_B/alu_cin driven from captured values; alu_Select = 3'b111 (park). Go EXEC.
- EXEC: alu_Select = captured opcode; operands held. The park-to-opcode transition makes every operation present a Select change to the ALU. Counter loaded with SETTLE_CYCLES-1, decrements; at 0 the edge samples alu_Output and flags into rsp_* regs, updates last_grant, go RESP.
- RESP: rsp_valid=1, rsp_* stable; alu_Select = 3'b111, operands held. On rsp_valid&rsp_ready go IDLE.
- Outside EXEC alu_Select is always 3'b111.
- Flags are passed through unmodified, with no reinterpretation of V for logic ops.
- New requests are never accepted outside IDLE. Requesters hold valid and payload until ready.

## Timing
- Reset (async assert, sync-safe release) forces: state IDLE, rsp_valid 0, rsp_id 0, rsp_Output 0, rsp_flags 0, alu_A/alu_B 0, alu_cin 0, alu_Select 3'b111, last_grant 1, counter 0, req ready 0.
- Reset mid-operation (LOAD/EXEC/RESP) discards the op. No response is produced.
- Acceptance at edge T0. LOAD during cycle T0..T1. EXEC spans SETTLE_CYCLES cycles. The sampling edge is T1+SETTLE_CYCLES. rsp_valid is high from that edge.
- Latency from accept edge to rsp_valid: 1+SETTLE_CYCLES cycles (2 at default).
- With rsp_ready tied high the response handshake takes 1 cycle. The next acceptance is the cycle after return to IDLE. Minimum issue interval: 3+SETTLE_CYCLES cycles.
- rsp_ready low holds RESP indefinitely. rsp_* must not change.
- A requester dropping valid in IDLE before grant has no effect on state.

## Test plan
- Reset: assert rst mid-EXEC -> immediately rsp_valid=0, alu_Select=3'b111, state IDLE; no response ever for that op. After release, first request accepted normally.
- Single add: req0 A=0x7FFFFFFF, B=1, cin=0, Select=000 -> rsp_valid 2 cycles after accept, rsp_id=0, rsp_Output=0x80000000, rsp_flags N=1, Z=0, V=1.
- Round-robin: both valid continuously, req0 xor (0xFFFF0000^0x0F0F0F0F), req1 nor (0,0) -> responses alternate id 0,1,0,1. Outputs are 0xF0F00F0F and 0xFFFFFFFF with Z=0.
- Backpressure: rsp_ready low 5 cycles after rsp_valid -> rsp_* stable; both reqN_ready=0 throughout. Handshake on cycle 6 returns to IDLE.
- Select 111 and shifts: req1 Select=111, A=3, B=4 -> ALU sees Select 000, result 7. Select=101, A=1, B=31 -> 0x80000000.
- SETTLE_CYCLES=4: accept edge to rsp_valid is exactly 5 cycles. alu_Select is 111 in LOAD and equals the opcode for exactly 4 cycles.
